// File: rtl/zuc256_arm_pkg.sv
// -----------------------------------------------------------------------------
// zuc256_arm_pkg
// Shared definitions for the zuc256_tot_wrapper initiator:
//   - wrapper command codes (READ/INIT/NEXT/FINAL/WRITE)
//   - job op encodings accepted on the job port
//   - initiator FSM state enum
//   - protocol primitive enum and the per-op sequence ROM
// -----------------------------------------------------------------------------
package zuc256_arm_pkg;

  localparam int unsigned DATA_W = 1024;
  localparam int unsigned CMD_W  = 32;

  localparam logic [CMD_W-1:0] CMD_READ  = 32'd0;
  localparam logic [CMD_W-1:0] CMD_INIT  = 32'd1;
  localparam logic [CMD_W-1:0] CMD_NEXT  = 32'd2;
  localparam logic [CMD_W-1:0] CMD_FINAL = 32'd3;
  localparam logic [CMD_W-1:0] CMD_WRITE = 32'd4;

  typedef enum logic [1:0] {
    OP_INIT  = 2'd0,
    OP_NEXT  = 2'd1,
    OP_FINAL = 2'd2,
    OP_RSVD  = 2'd3
  } job_op_e;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CMD       = 4'd1,
    ST_CMD_GAP   = 4'd2,
    ST_DATA_TX   = 4'd3,
    ST_DONE_WAIT = 4'd4,
    ST_DONE_ACK  = 4'd5,
    ST_DONE_GAP  = 4'd6,
    ST_DATA_RX   = 4'd7,
    ST_RESP      = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    PRIM_CMD  = 2'd0,
    PRIM_TX   = 2'd1,
    PRIM_RX   = 2'd2,
    PRIM_DONE = 2'd3
  } prim_e;

  typedef struct packed {
    prim_e              prim;
    logic [CMD_W-1:0]   cmd;
  } step_t;

  // Index of the final step of each sequence (step index is 3 bits wide).
  localparam logic [2:0] SEQ_LAST_INIT  = 3'd4;
  localparam logic [2:0] SEQ_LAST_NEXT  = 3'd7;
  localparam logic [2:0] SEQ_LAST_FINAL = 3'd4;

  // Sequence ROM: primitive (and command code for CMD steps) per op/step.
  function automatic step_t seq_rom(input logic [1:0] op, input logic [2:0] idx);
    step_t s;
    s.prim = PRIM_DONE;
    s.cmd  = CMD_READ;
    case (op)
      OP_INIT: begin
        case (idx)
          3'd0:    begin s.prim = PRIM_CMD;  s.cmd = CMD_READ; end
          3'd1:    begin s.prim = PRIM_TX;   s.cmd = CMD_READ; end
          3'd2:    begin s.prim = PRIM_DONE; s.cmd = CMD_READ; end
          3'd3:    begin s.prim = PRIM_CMD;  s.cmd = CMD_INIT; end
          default: begin s.prim = PRIM_DONE; s.cmd = CMD_READ; end
        endcase
      end
      OP_NEXT: begin
        case (idx)
          3'd0:    begin s.prim = PRIM_CMD;  s.cmd = CMD_READ;  end
          3'd1:    begin s.prim = PRIM_TX;   s.cmd = CMD_READ;  end
          3'd2:    begin s.prim = PRIM_DONE; s.cmd = CMD_READ;  end
          3'd3:    begin s.prim = PRIM_CMD;  s.cmd = CMD_NEXT;  end
          3'd4:    begin s.prim = PRIM_DONE; s.cmd = CMD_READ;  end
          3'd5:    begin s.prim = PRIM_CMD;  s.cmd = CMD_WRITE; end
          3'd6:    begin s.prim = PRIM_RX;   s.cmd = CMD_READ;  end
          default: begin s.prim = PRIM_DONE; s.cmd = CMD_READ;  end
        endcase
      end
      OP_FINAL: begin
        case (idx)
          3'd0:    begin s.prim = PRIM_CMD;  s.cmd = CMD_FINAL; end
          3'd1:    begin s.prim = PRIM_DONE; s.cmd = CMD_READ;  end
          3'd2:    begin s.prim = PRIM_CMD;  s.cmd = CMD_WRITE; end
          3'd3:    begin s.prim = PRIM_RX;   s.cmd = CMD_READ;  end
          default: begin s.prim = PRIM_DONE; s.cmd = CMD_READ;  end
        endcase
      end
      default: begin s.prim = PRIM_DONE; s.cmd = CMD_READ; end
    endcase
    return s;
  endfunction

  function automatic logic [2:0] seq_last(input logic [1:0] op);
    logic [2:0] l;
    case (op)
      OP_INIT:  l = SEQ_LAST_INIT;
      OP_NEXT:  l = SEQ_LAST_NEXT;
      OP_FINAL: l = SEQ_LAST_FINAL;
      default:  l = 3'd0;
    endcase
    return l;
  endfunction

  // FSM state that executes a given primitive.
  function automatic state_e prim_state(input prim_e p);
    state_e st;
    case (p)
      PRIM_CMD:  st = ST_CMD;
      PRIM_TX:   st = ST_DATA_TX;
      PRIM_RX:   st = ST_DATA_RX;
      PRIM_DONE: st = ST_DONE_WAIT;
      default:   st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/zuc256_arm_master.sv
// -----------------------------------------------------------------------------
// zuc256_arm_master
// Hardware initiator for the zuc256_tot_wrapper command/data protocol. Takes
// whole jobs (INIT/NEXT/FINAL) and expands each into the wrapper's
// command / data / done-handshake sequence, returning one response per job.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   job_valid/ready/op/data    job request port (ready only in IDLE)
//   res_valid/ready/data/err   response port (held stable until consumed)
//   busy                       FSM not in IDLE
//   arm_to_fpga_cmd[_valid]    one-cycle command strobe with command code
//   fpga_to_arm_done           wrapper step done
//   fpga_to_arm_done_read      one-cycle done acknowledge
//   arm_to_fpga_data[_valid/_ready]  outbound data handshake
//   fpga_to_arm_data[_valid/_ready]  inbound data handshake
// All outputs are registered; they are decoded from the next state so that
// each strobe lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module zuc256_arm_master
  import zuc256_arm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_op,
  input  logic [DATA_W-1:0] job_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy,
  output logic [CMD_W-1:0]  arm_to_fpga_cmd,
  output logic              arm_to_fpga_cmd_valid,
  input  logic              fpga_to_arm_done,
  output logic              fpga_to_arm_done_read,
  output logic              arm_to_fpga_data_valid,
  input  logic              arm_to_fpga_data_ready,
  output logic [DATA_W-1:0] arm_to_fpga_data,
  input  logic              fpga_to_arm_data_valid,
  output logic              fpga_to_arm_data_ready,
  input  logic [DATA_W-1:0] fpga_to_arm_data
);

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 32'd1);

  state_e             state_r;
  state_e             state_next_s;
  logic [2:0]         step_r;
  logic [2:0]         step_next_s;
  logic [1:0]         op_r;
  logic [DATA_W-1:0]  job_data_r;
  logic [DATA_W-1:0]  res_data_r;
  logic               res_err_r;
  logic               res_valid_r;
  logic               job_ready_r;
  logic               busy_r;
  logic [CMD_W-1:0]   cmd_r;
  logic [CMD_W-1:0]   cmd_code_s;
  logic               cmd_valid_r;
  logic               done_read_r;
  logic               tx_valid_r;
  logic               rx_ready_r;
  logic [31:0]        wd_r;

  logic               accept_s;
  logic               timeout_s;
  logic               capture_s;
  logic               wd_expire_s;
  logic               last_step_s;
  logic               wd_counting_s;
  step_t              first_step_s;
  step_t              adv_step_s;

  assign first_step_s  = seq_rom(job_op, 3'd0);
  assign adv_step_s    = seq_rom(op_r, step_r + 3'd1);
  assign last_step_s   = (step_r == seq_last(op_r));
  assign wd_expire_s   = (TIMEOUT_CYCLES != 32'd0) && (wd_r == WD_LIMIT);
  assign wd_counting_s = (state_r == ST_DATA_TX) || (state_r == ST_DONE_WAIT) ||
                         (state_r == ST_DATA_RX);

  // Next-state, step sequencing and event decode.
  always_comb begin
    state_next_s = state_r;
    step_next_s  = step_r;
    cmd_code_s   = cmd_r;
    accept_s     = 1'b0;
    timeout_s    = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (job_valid && job_ready_r) begin
          accept_s    = 1'b1;
          step_next_s = 3'd0;
          if (job_op == OP_RSVD) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = prim_state(first_step_s.prim);
            cmd_code_s   = first_step_s.cmd;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        state_next_s = ST_CMD_GAP;
      end
      // Both gap states close a step and launch the next one (or respond).
      ST_CMD_GAP, ST_DONE_GAP: begin
        if (last_step_s) begin
          state_next_s = ST_RESP;
        end else begin
          step_next_s  = step_r + 3'd1;
          state_next_s = prim_state(adv_step_s.prim);
          cmd_code_s   = adv_step_s.cmd;
        end
      end
      // TX/RX finish through CMD_GAP so valid/ready drops for one cycle.
      ST_DATA_TX: begin
        if (arm_to_fpga_data_ready) begin
          state_next_s = ST_CMD_GAP;
        end else if (wd_expire_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_DATA_TX;
        end
      end
      ST_DONE_WAIT: begin
        if (fpga_to_arm_done) begin
          state_next_s = ST_DONE_ACK;
        end else if (wd_expire_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_DONE_WAIT;
        end
      end
      ST_DONE_ACK: begin
        state_next_s = ST_DONE_GAP;
      end
      ST_DATA_RX: begin
        if (fpga_to_arm_data_valid) begin
          capture_s    = 1'b1;
          state_next_s = ST_CMD_GAP;
        end else if (wd_expire_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_DATA_RX;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, step index and latched job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      step_r     <= 3'd0;
      op_r       <= 2'd0;
      job_data_r <= '0;
    end else begin
      state_r <= state_next_s;
      step_r  <= step_next_s;
      if (accept_s) begin
        op_r       <= job_op;
        job_data_r <= job_data;
      end else if (timeout_s) begin
        job_data_r <= '0;
      end
    end
  end

  // Result register: cleared per job, loaded on inbound data, zeroed on abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_data_r <= '0;
      res_err_r  <= 1'b0;
    end else if (accept_s) begin
      res_data_r <= '0;
      res_err_r  <= (job_op == OP_RSVD);
    end else if (timeout_s) begin
      res_data_r <= '0;
      res_err_r  <= 1'b1;
    end else if (capture_s) begin
      res_data_r <= fpga_to_arm_data;
    end
  end

  // Watchdog: restarts on every state change, advances only in wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_r <= 32'd0;
    end else if (state_next_s != state_r) begin
      wd_r <= 32'd0;
    end else if (wd_counting_s) begin
      wd_r <= wd_r + 32'd1;
    end else begin
      wd_r <= 32'd0;
    end
  end

  // Registered protocol/port outputs decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r       <= '0;
      cmd_valid_r <= 1'b0;
      done_read_r <= 1'b0;
      tx_valid_r  <= 1'b0;
      rx_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      job_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cmd_valid_r <= (state_next_s == ST_CMD);
      done_read_r <= (state_next_s == ST_DONE_ACK);
      tx_valid_r  <= (state_next_s == ST_DATA_TX);
      rx_ready_r  <= (state_next_s == ST_DATA_RX);
      res_valid_r <= (state_next_s == ST_RESP);
      job_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      // cmd holds its last code between strobes; an abort clears it.
      if (state_next_s == ST_CMD) begin
        cmd_r <= cmd_code_s;
      end else if (timeout_s) begin
        cmd_r <= '0;
      end
    end
  end

  assign job_ready              = job_ready_r;
  assign res_valid              = res_valid_r;
  assign res_data               = res_data_r;
  assign res_err                = res_err_r;
  assign busy                   = busy_r;
  assign arm_to_fpga_cmd        = cmd_r;
  assign arm_to_fpga_cmd_valid  = cmd_valid_r;
  assign fpga_to_arm_done_read  = done_read_r;
  assign arm_to_fpga_data_valid = tx_valid_r;
  assign arm_to_fpga_data       = job_data_r;
  assign fpga_to_arm_data_ready = rx_ready_r;

endmodule

// File: doc/zuc256_arm_master.md
# zuc256_arm_master

Hardware initiator for the ARM↔FPGA command/data protocol spoken by `zuc256_tot_wrapper`. It accepts whole jobs (INIT, NEXT, FINAL) on a simple valid/ready job port and expands each into the exact command/data/done sequence the wrapper expects. It returns one response per job. It sits between an on-chip traffic source (DMA engine, soft CPU, or bench) and the wrapper, replacing the software driver.

## Interface
- `TIMEOUT_CYCLES`, 4096: maximum cycles spent in any single wait state before abort; 0 disables the watchdog.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  high only in IDLE.
- `job_op`  in  2  0=INIT, 1=NEXT, 2=FINAL, 3=reserved.
- `job_data`  in  1024  packed wrapper input word; used by INIT/NEXT only.
- `res_valid`  out  1  response available.
- `res_ready`  in  1  response consumed.
- `res_data`  out  1024  word read back from wrapper; 0 for INIT or error.
- `res_err`  out  1  set with `res_valid` on timeout or reserved op.
- `busy`  out  1  state != IDLE.
- `arm_to_fpga_cmd`  out  32  command code: READ=0, INIT=1, NEXT=2, FINAL=3, WRITE=4.
- `arm_to_fpga_cmd_valid`  out  1  one-cycle command strobe.
- `fpga_to_arm_done`  in  1  wrapper step done.
- `fpga_to_arm_done_read`  out  1  one-cycle done acknowledge.
- `arm_to_fpga_data_valid`  out  1  outbound data valid.
- `arm_to_fpga_data_ready`  in  1  wrapper accepted data.
- `arm_to_fpga_data`  out  1024  outbound data, driven from the latched job.
- `fpga_to_arm_data_valid`  in  1  inbound data valid.
- `fpga_to_arm_data_ready`  out  1  ready for inbound data.
- `fpga_to_arm_data`  in  1024  inbound data.

## Operation
- Sequences (steps run in order):
  - INIT: CMD(READ), TX, DONE, CMD(INIT), DONE.
  - NEXT: CMD(READ), TX, DONE, CMD(NEXT), DONE, CMD(WRITE), RX, DONE.
  - FINAL: CMD(FINAL), DONE, CMD(WRITE), RX, DONE.
- States: IDLE, CMD, CMD_GAP, DATA_TX, DONE_WAIT, DONE_ACK, DONE_GAP, DATA_RX, RESP.
- A 3-bit step index selects the next primitive from a per-op sequence ROM.
- Job accept: `job_valid && job_ready` at an edge latches `job_op` and `job_data`.
  - Reserved op goes directly to RESP with `res_err=1`.
- CMD step: `cmd_valid=1` for exactly one cycle with `cmd` set. CMD_GAP follows for one cycle with `cmd_valid=0`. `cmd` holds its last value.
- DATA_TX: `arm_to_fpga_data_valid=1` until an edge where `arm_to_fpga_data_ready=1`. `data_valid` drops the following cycle.
- DONE_WAIT: wait for `fpga_to_arm_done=1` sampled at an edge. DONE_ACK then drives `done_read=1` for one cycle. DONE_GAP follows for one idle cycle.
- DATA_RX: `fpga_to_arm_data_ready=1` until an edge where `fpga_to_arm_data_valid=1`. Capture `fpga_to_arm_data` into the result register on that edge; ready drops the next cycle.
- RESP: hold `res_valid`, `res_data`, `res_err` stable until `res_ready=1` at an edge, then return to IDLE.
- Watchdog:
  - The counter clears on every state entry and counts only in DATA_TX, DONE_WAIT and DATA_RX.
  - On reaching `TIMEOUT_CYCLES`: deassert all protocol outputs, set `res_err=1`, `res_data=0`, go to RESP.
- Simultaneous ready and valid on the first cycle of DATA_TX or DATA_RX completes the handshake in that cycle.

## Timing
- Reset values: all strobes/valids/readies 0, `cmd=0`, `arm_to_fpga_data=0`, `res_data=0`, `res_err=0`, `job_ready=0` during reset, state IDLE.
- `reset` asserted mid-job aborts immediately, with no response and no further strobes. The wrapper must be reset alongside.
- First `cmd_valid` appears the cycle after job acceptance.
- Minimum step cost with an instantly responding wrapper: CMD 2 cycles, TX 2, DONE 3, RX 2.
  - Minimum NEXT latency, accept to `res_valid`: 2+2+3+2+3+2+2+3 = 19 cycles.
- `job_ready` is low from the acceptance edge until the RESP handshake completes; jobs never overlap.

## Structure
- Package `zuc256_arm_pkg`: command codes, job op encodings, state enum, primitive enum (CMD/TX/RX/DONE), sequence length constants.
- Single module. No sub-module, except optional `zuc256_arm_watchdog` (loadable down-counter) if reused elsewhere.

## Test plan
- Real `zuc256_tot_wrapper`, key=iv=all-ones, enc_auth=0: INIT, then NEXT with block 0x01020304 → `res_data[31:0]=0x3887e1ab`. Then 0x05060708 → 0x3035d321, 0x090a0b0c → 0x3a8f8bfc, 0x0d0e0f00 → 0xedd603e9.
- Real wrapper, enc_auth=1, i_len=32, tag_len=128: INIT, 31 NEXT with block all-0x11, one NEXT with 0x11111111 followed by zeros, then FINAL → `res_data[127:0]=0xdd3a4017357803a51c3fb9a57a96feda`.
- Zero-latency behavioural responder: check every strobe is exactly one cycle wide and NEXT latency = 19 cycles.
- Responder never raises done, `TIMEOUT_CYCLES`=16: response after the wait state spends 16 cycles, `res_err=1`, `res_data=0`, all protocol outputs 0.
- `job_op=3` → response within 2 cycles with `res_err=1` and no `cmd_valid` pulse. Also: `res_ready` held low 10 cycles → outputs stable and `job_ready=0`.
- Reset asserted during DONE_WAIT of a NEXT job → next cycle all outputs at reset values. A following INIT job completes normally.
